// File: rtl/ifetch_queue.sv
// ifetch_queue: PC generator driving a 1-cycle synchronous imem, feeding decode through a show-ahead queue.
// Redirect flushes the queue and drops the in-flight response; issue is throttled so the queue never overflows.
module ifetch_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP = 1,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCSrc,
    input  logic [WIDTH-1:0] BrDest,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_ir,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] nPC,
    output logic [CW-1:0]    count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d, inflight_pc_q, inflight_pc_d;
    logic             inflight_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] pc_mem_q [DEPTH];
    logic [WIDTH-1:0] ir_mem_q [DEPTH];
    logic             push, pop;
    logic [CW:0]      occ;

    assign out_valid = !reset && (count_q != '0);
    assign count     = reset ? '0 : count_q;
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign out_ir    = ir_mem_q[rd_ptr_q];
    assign nPC       = out_pc + WIDTH'(STEP);
    assign pop       = out_valid & out_ready;
    assign push      = inflight_q & !PCSrc;
    // A pop this cycle frees a slot, so issue can continue without a bubble when full.
    assign occ       = {1'b0, count_q} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
    assign imem_req  = !reset && !PCSrc && (occ < DEPTH_C);
    assign imem_addr = fetch_pc_q;

    always_comb begin
        fetch_pc_d    = PCSrc ? BrDest : imem_req ? fetch_pc_q + WIDTH'(STEP) : fetch_pc_q;
        inflight_pc_d = imem_req ? fetch_pc_q : inflight_pc_q;
        wr_ptr_d      = PCSrc ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d      = PCSrc ? '0 : rd_ptr_q + AW'(pop);
        count_d       = PCSrc ? '0 : count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= imem_req;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            pc_mem_q[wr_ptr_q] <= inflight_pc_q;
            ir_mem_q[wr_ptr_q] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: table-driven vectors on the default configuration plus a hand-written
// sequence on a WIDTH=16, STEP=4, DEPTH=8 instance; imem model returns 0x1000 + address.
module tb_ifetch_queue;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b1, pcs0 = 1'b0, rdy0 = 1'b1;
    logic [31:0] br0 = '0, rdata0, addr0, ir0, pc0, npc0;
    logic        req0, vld0;
    logic [2:0]  cnt0;

    logic        rst1 = 1'b1, pcs1 = 1'b0, rdy1 = 1'b0;
    logic [15:0] br1 = '0, rdata1, addr1, ir1, pc1, npc1;
    logic        req1, vld1;
    logic [3:0]  cnt1;

    ifetch_queue u0 (
        .clk(clk), .reset(rst0), .PCSrc(pcs0), .BrDest(br0),
        .imem_req(req0), .imem_addr(addr0), .imem_rdata(rdata0),
        .out_valid(vld0), .out_ready(rdy0), .out_ir(ir0), .out_pc(pc0),
        .nPC(npc0), .count(cnt0)
    );

    ifetch_queue #(.WIDTH(16), .STEP(4), .RESET_PC(16'h0100), .DEPTH(8)) u1 (
        .clk(clk), .reset(rst1), .PCSrc(pcs1), .BrDest(br1),
        .imem_req(req1), .imem_addr(addr1), .imem_rdata(rdata1),
        .out_valid(vld1), .out_ready(rdy1), .out_ir(ir1), .out_pc(pc1),
        .nPC(npc1), .count(cnt1)
    );

    always @(posedge clk) begin
        rdata0 <= 32'h1000 + addr0;
        rdata1 <= 16'h1000 + addr1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("ovf0", 32'(cnt0 <= 3'd4), 32'd1);
        chk("ovf1", 32'(cnt1 <= 4'd8), 32'd1);
    endtask

    typedef struct {
        bit          rst, pcs, rdy, req, vld;
        logic [31:0] br, addr, pc;
        int          cnt;
    } vec_t;

    vec_t tbl[64];
    int   n = 0;

    task automatic add(input bit rst, input bit pcs, input logic [31:0] br, input bit rdy,
                       input bit req, input logic [31:0] addr, input bit vld,
                       input logic [31:0] pc, input int cnt);
        tbl[n] = '{rst: rst, pcs: pcs, rdy: rdy, req: req, vld: vld, br: br, addr: addr, pc: pc, cnt: cnt};
        n++;
    endtask

    initial begin
        // reset, then streaming with out_ready=1
        add(1, 0, 0, 1,  0, 0, 0, 0, 0);
        add(0, 0, 0, 1,  1, 0, 0, 0, 0);
        add(0, 0, 0, 1,  1, 1, 0, 0, 0);
        add(0, 0, 0, 1,  1, 2, 1, 0, 1);
        add(0, 0, 0, 1,  1, 3, 1, 1, 1);
        add(0, 0, 0, 1,  1, 4, 1, 2, 1);
        // reset with a non-empty queue, then fill with out_ready=0
        add(1, 0, 0, 0,  0, 0, 0, 0, 0);
        add(0, 0, 0, 0,  1, 0, 0, 0, 0);
        add(0, 0, 0, 0,  1, 1, 0, 0, 0);
        add(0, 0, 0, 0,  1, 2, 1, 0, 1);
        add(0, 0, 0, 0,  1, 3, 1, 0, 2);
        add(0, 0, 0, 0,  0, 0, 1, 0, 3);
        add(0, 0, 0, 0,  0, 0, 1, 0, 4);
        add(0, 0, 0, 0,  0, 0, 1, 0, 4);
        add(0, 0, 0, 1,  1, 4, 1, 0, 4);
        add(0, 0, 0, 1,  1, 5, 1, 1, 3);
        add(0, 0, 0, 1,  1, 6, 1, 2, 3);
        add(0, 0, 0, 1,  1, 7, 1, 3, 3);
        add(0, 0, 0, 1,  1, 8, 1, 4, 3);
        add(0, 0, 0, 1,  1, 9, 1, 5, 3);
        // redirect to 0x40 with 3 queued and one in flight
        add(0, 1, 32'h40, 1,  0, 0, 1, 6, 3);
        add(0, 0, 0, 1,  1, 32'h40, 0, 0, 0);
        add(0, 0, 0, 1,  1, 32'h41, 0, 0, 0);
        add(0, 0, 0, 1,  1, 32'h42, 1, 32'h40, 1);
        // redirect during a pop, then back-to-back redirects
        add(0, 1, 32'h10, 1,  0, 0, 1, 32'h41, 1);
        add(0, 1, 32'h20, 1,  0, 0, 0, 0, 0);
        add(0, 0, 0, 1,  1, 32'h20, 0, 0, 0);
        add(0, 0, 0, 1,  1, 32'h21, 0, 0, 0);
        add(0, 0, 0, 1,  1, 32'h22, 1, 32'h20, 1);
        add(0, 0, 0, 1,  1, 32'h23, 1, 32'h21, 1);
        // PC wrap at 2^32
        add(0, 1, 32'hFFFF_FFFF, 1,  0, 0, 1, 32'h22, 1);
        add(0, 0, 0, 1,  1, 32'hFFFF_FFFF, 0, 0, 0);
        add(0, 0, 0, 1,  1, 0, 0, 0, 0);
        add(0, 0, 0, 1,  1, 1, 1, 32'hFFFF_FFFF, 1);
        add(0, 0, 0, 1,  1, 2, 1, 0, 1);
        // build up a backlog, then reset with a request in flight
        add(0, 0, 0, 0,  1, 3, 1, 1, 1);
        add(0, 0, 0, 0,  1, 4, 1, 1, 2);
        add(1, 0, 0, 0,  0, 0, 0, 0, 0);
        add(1, 0, 0, 0,  0, 0, 0, 0, 0);
        add(0, 0, 0, 1,  1, 0, 0, 0, 0);
        add(0, 0, 0, 1,  1, 1, 0, 0, 0);
        add(0, 0, 0, 1,  1, 2, 1, 0, 1);
        add(0, 0, 0, 1,  1, 3, 1, 1, 1);

        tick();
        for (int i = 0; i < n; i++) begin
            rst0 = tbl[i].rst;
            pcs0 = tbl[i].pcs;
            br0  = tbl[i].br;
            rdy0 = tbl[i].rdy;
            #1;
            chk($sformatf("v%0d.req", i), 32'(req0), 32'(tbl[i].req));
            if (tbl[i].req) chk($sformatf("v%0d.addr", i), addr0, tbl[i].addr);
            chk($sformatf("v%0d.valid", i), 32'(vld0), 32'(tbl[i].vld));
            chk($sformatf("v%0d.count", i), 32'(cnt0), 32'(tbl[i].cnt));
            if (tbl[i].vld) begin
                chk($sformatf("v%0d.pc", i), pc0, tbl[i].pc);
                chk($sformatf("v%0d.ir", i), ir0, 32'h1000 + tbl[i].pc);
                chk($sformatf("v%0d.npc", i), npc0, tbl[i].pc + 32'd1);
            end
            tick();
        end

        // WIDTH=16, STEP=4, DEPTH=8, RESET_PC=0x100: fill to 8 entries with out_ready=0
        rst0 = 1'b0; pcs0 = 1'b0; rdy0 = 1'b1;
        rst1 = 1'b0; rdy1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("p.fill%0d.req", i), 32'(req1), 32'd1);
            chk($sformatf("p.fill%0d.addr", i), 32'(addr1), 32'h100 + 32'(4 * i));
            tick();
        end
        #1;
        chk("p.stop.req", 32'(req1), 32'd0);
        tick();
        #1;
        chk("p.full.req", 32'(req1), 32'd0);
        chk("p.full.count", 32'(cnt1), 32'd8);
        chk("p.full.valid", 32'(vld1), 32'd1);
        chk("p.full.pc", 32'(pc1), 32'h100);
        chk("p.full.ir", 32'(ir1), 32'h1100);
        chk("p.full.npc", 32'(npc1), 32'h104);
        rst1 = 1'b1;
        #1;
        chk("p.rst.req", 32'(req1), 32'd0);
        chk("p.rst.valid", 32'(vld1), 32'd0);
        chk("p.rst.count", 32'(cnt1), 32'd0);
        tick();
        #1;
        chk("p.rst2.req", 32'(req1), 32'd0);
        chk("p.rst2.valid", 32'(vld1), 32'd0);
        chk("p.rst2.count", 32'(cnt1), 32'd0);
        tick();
        rst1 = 1'b0; rdy1 = 1'b1;
        #1;
        chk("p.rel.req", 32'(req1), 32'd1);
        chk("p.rel.addr", 32'(addr1), 32'h100);
        tick();
        #1;
        chk("p.rel1.addr", 32'(addr1), 32'h104);
        chk("p.rel1.valid", 32'(vld1), 32'd0);
        tick();
        #1;
        chk("p.rel2.valid", 32'(vld1), 32'd1);
        chk("p.rel2.pc", 32'(pc1), 32'h100);
        pcs1 = 1'b1; br1 = 16'hFFFC;
        #1;
        chk("p.br.req", 32'(req1), 32'd0);
        tick();
        pcs1 = 1'b0;
        #1;
        chk("p.wrap0.addr", 32'(addr1), 32'hFFFC);
        chk("p.wrap0.valid", 32'(vld1), 32'd0);
        tick();
        #1;
        chk("p.wrap1.addr", 32'(addr1), 32'h0000);
        tick();
        #1;
        chk("p.wrap2.valid", 32'(vld1), 32'd1);
        chk("p.wrap2.pc", 32'(pc1), 32'hFFFC);
        chk("p.wrap2.ir", 32'(ir1), 32'h0FFC);
        chk("p.wrap2.npc", 32'(npc1), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
